cam_sccb_config: RTL and testbench

Power-up configuration sequencer for the OV7670. It walks an external register table and issues one SCCB 3-phase write per entry: device ID, register address, then data. It honours delay and end markers in the table. It sits on the system clock beside the capture path and asserts done once the sensor is configured, so downstream logic can gate frame capture on it.

---
 rtl/cam_cfg_pkg.sv | 35 +++
 rtl/sccb_write3.sv | 112 +++++++++++
 rtl/cam_sccb_config.sv | 164 ++++++++++++++++
 tb/tb_cam_sccb_config.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cam_cfg_pkg.sv
// Shared definitions for the OV7670 SCCB configuration sequencer:
// table markers, default device ID and the FSM state encodings.
package cam_cfg_pkg;

    localparam logic [15:0] TBL_END       = 16'hFFFF;
    localparam logic [7:0]  TBL_DELAY_HI  = 8'hFE;
    localparam logic [7:0]  DEVICE_ID_DEF = 8'h42;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_FETCH,
        ST_WAIT1,
        ST_DECODE,
        ST_XFER,
        ST_GAP,
        ST_DELAY,
        ST_NEXT,
        ST_DONE
    } cfg_state_e;

    typedef enum logic [1:0] {
        WR_IDLE,
        WR_START,
        WR_BITS,
        WR_STOP
    } wr_state_e;

    // Integer divide that never yields a zero-length period.
    function automatic logic [31:0] div_min1(input int unsigned num, input int unsigned den);
        logic [31:0] q;
        q = num / den;
        return (q == 32'd0) ? 32'd1 : q;
    endfunction

endpackage

// File: rtl/sccb_write3.sv
// 3-phase SCCB write engine: START, id/addr/data bytes each followed by a
// released don't-care bit, then STOP. Every bit slot is four quarter ticks.
//
// state    | meaning
// WR_IDLE  | bus idle (SIOC high, SIOD released), waiting for go
// WR_START | SIOD low with SIOC high in q0, SIOC falls in q1
// WR_BITS  | 27 slots: 3 x (8 data bits MSB first + 1 released bit)
// WR_STOP  | SIOC rises in q1 with SIOD low, SIOD released from q2
module sccb_write3
    import cam_cfg_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       go_i,
    input  logic [7:0] id_i,
    input  logic [7:0] addr_i,
    input  logic [7:0] data_i,
    input  logic       tick_i,
    output logic       sioc_o,
    output logic       siod_pull_low_o,
    output logic       done_o
);

    wr_state_e   state_q, state_d;
    logic [1:0]  qtr_q, qtr_d;
    logic [3:0]  pos_q, pos_d;
    logic [1:0]  byte_q, byte_d;
    logic [23:0] sh_q, sh_d;
    logic        slot_end;

    assign slot_end = tick_i && (qtr_q == 2'd3);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= WR_IDLE;
            qtr_q   <= 2'd0;
            pos_q   <= 4'd0;
            byte_q  <= 2'd0;
            sh_q    <= 24'd0;
        end else begin
            state_q <= state_d;
            qtr_q   <= qtr_d;
            pos_q   <= pos_d;
            byte_q  <= byte_d;
            sh_q    <= sh_d;
        end
    end

    always_comb begin
        state_d = state_q;
        qtr_d   = qtr_q;
        pos_d   = pos_q;
        byte_d  = byte_q;
        sh_d    = sh_q;
        if (tick_i && (state_q != WR_IDLE)) begin
            qtr_d = qtr_q + 2'd1;
        end
        unique case (state_q)
            WR_IDLE: begin
                if (go_i) begin
                    state_d = WR_START;
                    qtr_d   = 2'd0;
                    pos_d   = 4'd0;
                    byte_d  = 2'd0;
                    sh_d    = {id_i, addr_i, data_i};
                end
            end
            WR_START: begin
                if (slot_end) state_d = WR_BITS;
            end
            WR_BITS: begin
                if (slot_end) begin
                    if (pos_q == 4'd8) begin
                        pos_d = 4'd0;
                        if (byte_q == 2'd2) state_d = WR_STOP;
                        else                byte_d  = byte_q + 2'd1;
                    end else begin
                        pos_d = pos_q + 4'd1;
                        sh_d  = {sh_q[22:0], 1'b0};
                    end
                end
            end
            WR_STOP: begin
                if (slot_end) state_d = WR_IDLE;
            end
            default: state_d = WR_IDLE;
        endcase
    end

    always_comb begin
        sioc_o          = 1'b1;
        siod_pull_low_o = 1'b0;
        done_o          = 1'b0;
        unique case (state_q)
            WR_START: begin
                sioc_o          = (qtr_q == 2'd0);
                siod_pull_low_o = 1'b1;
            end
            WR_BITS: begin
                sioc_o          = (qtr_q == 2'd1) || (qtr_q == 2'd2);
                siod_pull_low_o = (pos_q != 4'd8) && !sh_q[23];
            end
            WR_STOP: begin
                sioc_o          = (qtr_q != 2'd0);
                siod_pull_low_o = (qtr_q <= 2'd1);
                done_o          = slot_end;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/cam_sccb_config.sv
// OV7670 power-up configuration sequencer: walks an external register table
// and issues one SCCB write per entry, honouring delay and end markers.
//
// state     | meaning
// ST_IDLE   | post-reset, waiting for start
// ST_FETCH  | rom_addr presented to the table
// ST_WAIT1  | table read latency
// ST_DECODE | classify entry: end / delay / register write
// ST_XFER   | SCCB frame in flight
// ST_GAP    | 4 quarter ticks of idle bus after a frame
// ST_DELAY  | millisecond wait from a delay marker
// ST_NEXT   | advance to the next entry or finish at the last address
// ST_DONE   | configuration complete, waiting for a restart
module cam_sccb_config
    import cam_cfg_pkg::*;
#(
    parameter int unsigned CLK_FREQ_HZ  = 25_000_000,
    parameter int unsigned SCCB_FREQ_HZ = 100_000,
    parameter logic [7:0]  DEVICE_ID    = DEVICE_ID_DEF,
    parameter int unsigned ROM_AW       = 8
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    output logic [ROM_AW-1:0] rom_addr_o,
    input  logic [15:0]       rom_data_i,
    output logic              sioc_o,
    output logic              siod_pull_low_o,
    output logic              busy_o,
    output logic              done_o
);

    localparam logic [31:0]       DIV       = div_min1(CLK_FREQ_HZ, 4 * SCCB_FREQ_HZ);
    localparam logic [31:0]       MS_DIV    = div_min1(CLK_FREQ_HZ, 1000);
    localparam logic [ROM_AW-1:0] ADDR_LAST = '1;

    cfg_state_e        state_q, state_d;
    logic [ROM_AW-1:0] addr_q, addr_d;
    logic [31:0]       tick_cnt_q, tick_cnt_d;
    logic [31:0]       ms_cyc_q, ms_cyc_d;
    logic [7:0]        ms_q, ms_d;
    logic [1:0]        gap_q, gap_d;
    logic              tick;
    logic              running;
    logic              is_end, is_delay;
    logic              wr_go, wr_done;

    assign is_end   = (rom_data_i == TBL_END);
    assign is_delay = (rom_data_i[15:8] == TBL_DELAY_HI);
    assign running  = (state_q != ST_IDLE) && (state_q != ST_DONE);

    // Quarter-bit down-counter; parked at zero while the walker is idle.
    always_comb begin
        tick       = 1'b0;
        tick_cnt_d = 32'd0;
        if (running) begin
            if (tick_cnt_q == 32'd0) begin
                tick       = 1'b1;
                tick_cnt_d = DIV - 32'd1;
            end else begin
                tick_cnt_d = tick_cnt_q - 32'd1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= ST_IDLE;
            addr_q     <= '0;
            tick_cnt_q <= 32'd0;
            ms_cyc_q   <= 32'd0;
            ms_q       <= 8'd0;
            gap_q      <= 2'd0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            tick_cnt_q <= tick_cnt_d;
            ms_cyc_q   <= ms_cyc_d;
            ms_q       <= ms_d;
            gap_q      <= gap_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        ms_cyc_d = ms_cyc_q;
        ms_d     = ms_q;
        gap_d    = gap_q;
        unique case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start_i) begin
                    state_d = ST_FETCH;
                    addr_d  = '0;
                end
            end
            ST_FETCH: state_d = ST_WAIT1;
            ST_WAIT1: state_d = ST_DECODE;
            ST_DECODE: begin
                if (is_end) begin
                    state_d = ST_DONE;
                end else if (is_delay) begin
                    ms_d     = rom_data_i[7:0];
                    ms_cyc_d = MS_DIV - 32'd1;
                    state_d  = (rom_data_i[7:0] == 8'd0) ? ST_NEXT : ST_DELAY;
                end else begin
                    state_d = ST_XFER;
                end
            end
            ST_XFER: begin
                if (wr_done) begin
                    state_d = ST_GAP;
                    gap_d   = 2'd3;
                end
            end
            ST_GAP: begin
                if (tick) begin
                    if (gap_q == 2'd0) state_d = ST_NEXT;
                    else               gap_d   = gap_q - 2'd1;
                end
            end
            ST_DELAY: begin
                if (ms_cyc_q == 32'd0) begin
                    ms_cyc_d = MS_DIV - 32'd1;
                    ms_d     = ms_q - 8'd1;
                    if (ms_q == 8'd1) state_d = ST_NEXT;
                end else begin
                    ms_cyc_d = ms_cyc_q - 32'd1;
                end
            end
            ST_NEXT: begin
                // The last table slot ends the walk rather than wrapping to 0.
                if (addr_q == ADDR_LAST) begin
                    state_d = ST_DONE;
                end else begin
                    addr_d  = addr_q + 1'b1;
                    state_d = ST_FETCH;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        busy_o     = running;
        done_o     = (state_q == ST_DONE);
        wr_go      = (state_q == ST_DECODE) && !is_end && !is_delay;
        rom_addr_o = addr_q;
    end

    sccb_write3 u_write3 (
        .clk_i           (clk_i),
        .rst_i           (rst_i),
        .go_i            (wr_go),
        .id_i            (DEVICE_ID),
        .addr_i          (rom_data_i[15:8]),
        .data_i          (rom_data_i[7:0]),
        .tick_i          (tick),
        .sioc_o          (sioc_o),
        .siod_pull_low_o (siod_pull_low_o),
        .done_o          (wr_done)
    );

endmodule

// File: tb/tb_cam_sccb_config.sv
// Bench for cam_sccb_config: a bus-level SCCB decoder turns SIOC/SIOD into
// frames, which are compared against frames predicted from the table contents.
module tb_cam_sccb_config;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start_a = 1'b0, start_b = 1'b0;
    logic [7:0]  rom_addr_a;
    logic [1:0]  rom_addr_b;
    logic [15:0] rom_data_a, rom_data_b;
    logic        sioc_a, pull_a, busy_a, done_a;
    logic        sioc_b, pull_b, busy_b, done_b;

    logic [15:0] rom_a [256];
    logic [15:0] rom_b [4];

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    always @(posedge clk) rom_data_a <= rom_a[rom_addr_a];
    always @(posedge clk) rom_data_b <= rom_b[rom_addr_b];

    cam_sccb_config #(.CLK_FREQ_HZ(4_000_000), .SCCB_FREQ_HZ(100_000),
                      .DEVICE_ID(8'h42), .ROM_AW(8)) dut_a (
        .clk_i(clk), .rst_i(rst), .start_i(start_a), .rom_addr_o(rom_addr_a),
        .rom_data_i(rom_data_a), .sioc_o(sioc_a), .siod_pull_low_o(pull_a),
        .busy_o(busy_a), .done_o(done_a));

    cam_sccb_config #(.CLK_FREQ_HZ(4_000_000), .SCCB_FREQ_HZ(100_000),
                      .DEVICE_ID(8'h42), .ROM_AW(2)) dut_b (
        .clk_i(clk), .rst_i(rst), .start_i(start_b), .rom_addr_o(rom_addr_b),
        .rom_data_i(rom_data_b), .sioc_o(sioc_b), .siod_pull_low_o(pull_b),
        .busy_o(busy_b), .done_o(done_b));

    // Bus decoder state, one slot per DUT instance
    logic [23:0] frm_a [$];
    logic [23:0] frm_b [$];
    logic [23:0] exp_q [$];
    int          edges [2];
    int          bitcnt [2];
    logic [27:0] shreg [2];
    bit          in_frame [2];
    logic        p_sioc [2];
    logic        p_siod [2];
    int          nfr [2];
    int          last_stop [2];
    int          last_gap [2];
    int          cyc = 0;

    initial begin
        logic c, d;
        for (int k = 0; k < 2; k++) begin
            edges[k] = 0; bitcnt[k] = 0; shreg[k] = '0; in_frame[k] = 0;
            p_sioc[k] = 1'b1; p_siod[k] = 1'b1; nfr[k] = 0;
            last_stop[k] = 0; last_gap[k] = 0;
        end
        forever begin
            @(negedge clk);
            cyc++;
            for (int k = 0; k < 2; k++) begin
                c = (k == 0) ? sioc_a : sioc_b;
                d = (k == 0) ? !pull_a : !pull_b;
                if (c != p_sioc[k]) edges[k]++;
                if (p_sioc[k] && c && p_siod[k] && !d) begin
                    in_frame[k] = 1;
                    bitcnt[k]   = 0;
                    if (nfr[k] > 0) last_gap[k] = cyc - last_stop[k];
                end else if (p_sioc[k] && c && !p_siod[k] && d) begin
                    // 27 payload bits plus the rising SIOC edge that opens STOP
                    if (in_frame[k] && bitcnt[k] == 28) begin
                        if (k == 0) frm_a.push_back({shreg[k][27:20], shreg[k][18:11], shreg[k][9:2]});
                        else        frm_b.push_back({shreg[k][27:20], shreg[k][18:11], shreg[k][9:2]});
                        nfr[k]++;
                        last_stop[k] = cyc;
                    end
                    in_frame[k] = 0;
                end else if (!p_sioc[k] && c) begin
                    shreg[k]  = {shreg[k][26:0], d};
                    bitcnt[k] = bitcnt[k] + 1;
                end
                p_sioc[k] = c;
                p_siod[k] = d;
            end
        end
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    // Reference: each table entry in order until the end marker or the last
    // address; delay markers produce no frame, all else produces {ID, entry}.
    task automatic model_walk(input int which, input int last, output int fin_addr);
        int idx = 0;
        logic [15:0] e;
        exp_q.delete();
        while (1) begin
            e = (which == 0) ? rom_a[idx] : rom_b[idx];
            if (e == 16'hFFFF) break;
            if (e[15:8] != 8'hFE) exp_q.push_back({8'h42, e});
            if (idx == last) break;
            idx++;
        end
        fin_addr = idx;
    endtask

    task automatic cmp_frames(input int k);
        int na = (k == 0) ? frm_a.size() : frm_b.size();
        chk("frame_count", na, exp_q.size());
        for (int i = 0; i < exp_q.size() && i < na; i++)
            chk("frame_bytes", (k == 0) ? frm_a[i] : frm_b[i], exp_q[i]);
    endtask

    task automatic pulse_start(input int k);
        @(negedge clk);
        if (k == 0) start_a = 1'b1; else start_b = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        start_b = 1'b0;
    endtask

    task automatic wait_done(input int k, input int budget);
        int n = 0;
        while (((k == 0) ? done_a : done_b) !== 1'b1 && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk("done_seen", (k == 0) ? done_a : done_b, 1'b1);
    endtask

    task automatic wait_bits(input int min_bits, input int budget);
        int n = 0;
        while (!(in_frame[0] && bitcnt[0] >= min_bits) && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk("reach_bit", in_frame[0] && bitcnt[0] >= min_bits, 1'b1);
    endtask

    task automatic load_a(input logic [15:0] e0, e1, e2, e3);
        for (int i = 0; i < 256; i++) rom_a[i] = 16'hFFFF;
        rom_a[0] = e0; rom_a[1] = e1; rom_a[2] = e2; rom_a[3] = e3;
    endtask

    typedef struct {
        logic [3:0][15:0] tbl;
        int               exp_frames;
        int               exp_addr;
        int               min_gap;
    } vec_t;

    function automatic vec_t mk(input logic [15:0] e0, e1, e2, e3,
                                input int nf, input int ea, input int mg);
        vec_t v;
        v.tbl[0] = e0; v.tbl[1] = e1; v.tbl[2] = e2; v.tbl[3] = e3;
        v.exp_frames = nf; v.exp_addr = ea; v.min_gap = mg;
        return v;
    endfunction

    initial begin
        vec_t vecs [4];
        int   fa, n, e0;
        logic [15:0] r [4];

        vecs[0] = mk(16'h1280, 16'hFFFF, 16'hFFFF, 16'hFFFF, 1, 1, 0);
        vecs[1] = mk(16'h1101, 16'hFE02, 16'h40D0, 16'hFFFF, 2, 3, 8000);
        vecs[2] = mk(16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 0, 0, 0);
        vecs[3] = mk(16'hFE00, 16'h3A04, 16'hFFFF, 16'hFFFF, 1, 2, 0);

        for (int i = 0; i < 256; i++) rom_a[i] = 16'hFFFF;
        for (int i = 0; i < 4; i++) rom_b[i] = 16'hFFFF;

        repeat (4) @(negedge clk);
        chk("rst_sioc", sioc_a, 1'b1);
        chk("rst_pull", pull_a, 1'b0);
        chk("rst_busy", busy_a, 1'b0);
        chk("rst_done", done_a, 1'b0);
        chk("rst_addr", rom_addr_a, 8'd0);
        rst = 1'b0;

        for (int v = 0; v < 4; v++) begin
            load_a(vecs[v].tbl[0], vecs[v].tbl[1], vecs[v].tbl[2], vecs[v].tbl[3]);
            frm_a.delete();
            pulse_start(0);
            wait_done(0, 15000);
            model_walk(0, 255, fa);
            chk("vec_frames", frm_a.size(), vecs[v].exp_frames);
            cmp_frames(0);
            chk("vec_addr", rom_addr_a, vecs[v].exp_addr);
            chk("vec_busy", busy_a, 1'b0);
            if (vecs[v].min_gap > 0) chk("vec_gap", last_gap[0] >= vecs[v].min_gap, 1'b1);
        end

        // End marker only: done within 3 cycles, bus untouched
        load_a(16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF);
        e0 = edges[0];
        @(negedge clk); start_a = 1'b1;
        @(negedge clk); start_a = 1'b0;
        chk("busy_after_start", busy_a, 1'b1);
        n = 0;
        while (!done_a && n < 4) begin @(negedge clk); n++; end
        chk("end_only_latency", n <= 3 && done_a, 1'b1);
        repeat (20) @(negedge clk);
        chk("end_only_edges", edges[0], e0);

        // Start while busy is ignored; start after done replays from entry 0
        load_a(16'h1280, 16'h3355, 16'hFFFF, 16'hFFFF);
        model_walk(0, 255, fa);
        for (int rep = 0; rep < 2; rep++) begin
            frm_a.delete();
            pulse_start(0);
            chk("restart_addr0", rom_addr_a, 8'd0);
            if (rep == 0) begin
                wait_bits(5, 3000);
                pulse_start(0);
            end
            wait_done(0, 15000);
            cmp_frames(0);
            chk("restart_final_addr", rom_addr_a, fa);
        end

        // Randomized tables
        for (int t = 0; t < 3; t++) begin
            for (int i = 0; i < 4; i++) begin
                if ($urandom_range(0, 3) == 0) r[i] = 16'hFE00;
                else r[i] = {8'($urandom_range(0, 253)), 8'($urandom_range(0, 255))};
            end
            r[$urandom_range(1, 3)] = 16'hFFFF;
            load_a(r[0], r[1], r[2], r[3]);
            frm_a.delete();
            model_walk(0, 255, fa);
            pulse_start(0);
            wait_done(0, 15000);
            cmp_frames(0);
            chk("rand_addr", rom_addr_a, fa);
        end

        // Reset during a data bit of the third byte
        load_a(16'h1280, 16'hFFFF, 16'hFFFF, 16'hFFFF);
        frm_a.delete();
        pulse_start(0);
        wait_bits(20, 3000);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("midrst_sioc", sioc_a, 1'b1);
        chk("midrst_pull", pull_a, 1'b0);
        chk("midrst_busy", busy_a, 1'b0);
        chk("midrst_done", done_a, 1'b0);
        chk("midrst_addr", rom_addr_a, 8'd0);
        @(negedge clk); rst = 1'b0;
        #1 e0 = edges[0];
        repeat (2000) @(negedge clk);
        chk("midrst_no_edges", edges[0], e0);
        chk("midrst_no_frame", frm_a.size(), 0);
        chk("midrst_idle", busy_a, 1'b0);

        // Small table address space, no end marker: stops at the last slot
        for (int i = 0; i < 4; i++)
            rom_b[i] = {8'($urandom_range(0, 253)), 8'($urandom_range(0, 255))};
        frm_b.delete();
        model_walk(1, 3, fa);
        pulse_start(1);
        wait_done(1, 8000);
        cmp_frames(1);
        chk("nowrap_addr", rom_addr_b, 2'd3);
        repeat (50) @(negedge clk);
        chk("nowrap_hold_addr", rom_addr_b, 2'd3);
        chk("nowrap_hold_done", done_b, 1'b1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
